// File: rtl/gfp8_pkg.sv
// Shared types and constants for the GFP8 native-vector dot sequencer.
package gfp8_pkg;

    typedef logic signed [31:0] gfp_man_t;
    typedef logic signed [7:0]  gfp_exp_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } seq_state_e;

    // Alignment shifts beyond this flush the operand to zero.
    localparam int unsigned SHIFT_LIMIT = 31;

    localparam gfp_man_t MAN_MAX = 32'sh7FFF_FFFF;
    localparam gfp_man_t MAN_MIN = 32'sh8000_0000;

endpackage

// File: rtl/gfp8_acc_align.sv
// Combinational exponent alignment and saturating add of two GFP (mantissa, exponent) pairs.
module gfp8_acc_align
    import gfp8_pkg::*;
(
    input  gfp_man_t i_a_m,
    input  gfp_exp_t i_a_e,
    input  gfp_man_t i_b_m,
    input  gfp_exp_t i_b_e,
    output gfp_man_t o_sum_m,
    output gfp_exp_t o_emax
);

    gfp_man_t    a_sh;
    gfp_man_t    b_sh;
    logic [32:0] sum;

    function automatic gfp_man_t align_to(input gfp_man_t m, input gfp_exp_t e, input gfp_exp_t emax);
        logic [8:0] diff;
        diff = $signed({emax[7], emax}) - $signed({e[7], e});
        if (diff > 9'(SHIFT_LIMIT)) begin
            return '0;
        end
        return m >>> diff[4:0];
    endfunction

    always_comb begin
        o_emax  = (i_a_e > i_b_e) ? i_a_e : i_b_e;
        a_sh    = align_to(i_a_m, i_a_e, o_emax);
        b_sh    = align_to(i_b_m, i_b_e, o_emax);
        sum     = {a_sh[31], a_sh} + {b_sh[31], b_sh};
        o_sum_m = sum[31:0];
        if (sum[32] != sum[31]) begin
            o_sum_m = sum[32] ? MAN_MIN : MAN_MAX;
        end
    end

endmodule

// File: rtl/gfp8_nv_dot_seq.sv
// Streams NV operand pairs into the dot unit and folds its results into one GFP element.
//   state | meaning
//   IDLE  | ready for a command
//   FETCH | issuing one operand read per cycle
//   DRAIN | waiting for the remaining dot results
//   DONE  | holding the accumulated result until accepted
module gfp8_nv_dot_seq
    import gfp8_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int CNT_W   = 8,
    parameter int DOT_LAT = 3,
    parameter int RD_LAT  = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_left_base,
    input  logic [ADDR_W-1:0] i_cmd_right_base,
    input  logic [CNT_W-1:0]  i_cmd_num_nv,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr_left,
    output logic [ADDR_W-1:0] o_rd_addr_right,
    output logic              o_dot_input_valid,
    input  gfp_man_t          i_dot_mantissa,
    input  gfp_exp_t          i_dot_exponent,
    output logic              o_result_valid,
    input  logic              i_result_ready,
    output gfp_man_t          o_result_mantissa,
    output gfp_exp_t          o_result_exponent,
    output logic              o_busy
);

    localparam int PIPE_LEN = RD_LAT + DOT_LAT;

    seq_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   left_base_q, left_base_d;
    logic [ADDR_W-1:0]   right_base_q, right_base_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
    logic [PIPE_LEN-1:0] vpipe_q, vpipe_d;
    gfp_man_t            acc_m_q, acc_m_d;
    gfp_exp_t            acc_e_q, acc_e_d;
    logic                first_q, first_d;

    logic     rd_en;
    logic     res_v;
    gfp_man_t sum_m;
    gfp_exp_t sum_e;

    assign rd_en = (state_q == FETCH);
    // One shift register covers both the buffer read latency and the dot latency.
    assign res_v = vpipe_q[PIPE_LEN-1];

    gfp8_acc_align u_align (
        .i_a_m   (acc_m_q),
        .i_a_e   (acc_e_q),
        .i_b_m   (i_dot_mantissa),
        .i_b_e   (i_dot_exponent),
        .o_sum_m (sum_m),
        .o_emax  (sum_e)
    );

    always_comb begin
        state_d      = state_q;
        left_base_d  = left_base_q;
        right_base_d = right_base_q;
        num_d        = num_q;
        rd_cnt_d     = rd_cnt_q;
        res_cnt_d    = res_cnt_q;
        acc_m_d      = acc_m_q;
        acc_e_d      = acc_e_q;
        first_d      = first_q;
        vpipe_d      = {vpipe_q[PIPE_LEN-2:0], rd_en};

        if (res_v) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
            first_d   = 1'b0;
            if (first_q) begin
                acc_m_d = i_dot_mantissa;
                acc_e_d = i_dot_exponent;
            end else begin
                acc_m_d = sum_m;
                acc_e_d = sum_e;
            end
        end

        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    left_base_d  = i_cmd_left_base;
                    right_base_d = i_cmd_right_base;
                    num_d        = i_cmd_num_nv;
                    rd_cnt_d     = '0;
                    res_cnt_d    = '0;
                    acc_m_d      = '0;
                    acc_e_d      = '0;
                    first_d      = 1'b1;
                    state_d      = (i_cmd_num_nv == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (rd_cnt_q == num_q - CNT_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (res_cnt_d == num_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            left_base_q  <= '0;
            right_base_q <= '0;
            num_q        <= '0;
            rd_cnt_q     <= '0;
            res_cnt_q    <= '0;
            vpipe_q      <= '0;
            acc_m_q      <= '0;
            acc_e_q      <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            left_base_q  <= left_base_d;
            right_base_q <= right_base_d;
            num_q        <= num_d;
            rd_cnt_q     <= rd_cnt_d;
            res_cnt_q    <= res_cnt_d;
            vpipe_q      <= vpipe_d;
            acc_m_q      <= acc_m_d;
            acc_e_q      <= acc_e_d;
            first_q      <= first_d;
        end
    end

    assign o_cmd_ready       = (state_q == IDLE);
    assign o_busy            = (state_q != IDLE);
    assign o_rd_en           = rd_en;
    assign o_rd_addr_left    = left_base_q + ADDR_W'(rd_cnt_q);
    assign o_rd_addr_right   = right_base_q + ADDR_W'(rd_cnt_q);
    assign o_dot_input_valid = vpipe_q[RD_LAT-1];
    assign o_result_valid    = (state_q == DONE);
    assign o_result_mantissa = acc_m_q;
    assign o_result_exponent = acc_e_q;

endmodule

// File: tb/tb_gfp8_nv_dot_seq.sv
// Bench for gfp8_nv_dot_seq: a table-driven dot-unit model plus a list-fold reference of the accumulation.
module tb_gfp8_nv_dot_seq;

    localparam longint LMAX = 2147483647;
    localparam longint LMIN = -LMAX - 1;

    logic               i_clk = 1'b0;
    logic               i_reset_n;
    logic               i_cmd_valid;
    logic               o_cmd_ready;
    logic [8:0]         i_cmd_left_base;
    logic [8:0]         i_cmd_right_base;
    logic [7:0]         i_cmd_num_nv;
    logic               o_rd_en;
    logic [8:0]         o_rd_addr_left;
    logic [8:0]         o_rd_addr_right;
    logic               o_dot_input_valid;
    logic signed [31:0] i_dot_mantissa;
    logic signed [7:0]  i_dot_exponent;
    logic               o_result_valid;
    logic               i_result_ready;
    logic signed [31:0] o_result_mantissa;
    logic signed [7:0]  o_result_exponent;
    logic               o_busy;

    gfp8_nv_dot_seq dut (
        .i_clk             (i_clk),
        .i_reset_n         (i_reset_n),
        .i_cmd_valid       (i_cmd_valid),
        .o_cmd_ready       (o_cmd_ready),
        .i_cmd_left_base   (i_cmd_left_base),
        .i_cmd_right_base  (i_cmd_right_base),
        .i_cmd_num_nv      (i_cmd_num_nv),
        .o_rd_en           (o_rd_en),
        .o_rd_addr_left    (o_rd_addr_left),
        .o_rd_addr_right   (o_rd_addr_right),
        .o_dot_input_valid (o_dot_input_valid),
        .i_dot_mantissa    (i_dot_mantissa),
        .i_dot_exponent    (i_dot_exponent),
        .o_result_valid    (o_result_valid),
        .i_result_ready    (i_result_ready),
        .o_result_mantissa (o_result_mantissa),
        .o_result_exponent (o_result_exponent),
        .o_busy            (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    // Dot result for an NV pair is looked up by its left address.
    int tab_m[512];
    int tab_e[512];

    bit         hv[4];
    logic [8:0] hla[4];
    int rd_la_q[$];
    int rd_ra_q[$];
    int rd_cyc_q[$];
    int dv_cyc_q[$];

    always @(posedge i_clk) cyc = cyc + 1;

    // Read issued in cycle c yields its dot result during cycle c+4; otherwise the bus carries junk.
    always @(negedge i_clk) begin
        if (hv[3]) begin
            i_dot_mantissa = tab_m[hla[3]];
            i_dot_exponent = 8'(tab_e[hla[3]]);
        end else begin
            i_dot_mantissa = $urandom;
            i_dot_exponent = 8'($urandom);
        end
        for (int i = 3; i > 0; i--) begin
            hv[i]  = hv[i-1];
            hla[i] = hla[i-1];
        end
        hv[0]  = o_rd_en;
        hla[0] = o_rd_addr_left;
        if (o_rd_en) begin
            rd_la_q.push_back(int'(o_rd_addr_left));
            rd_ra_q.push_back(int'(o_rd_addr_right));
            rd_cyc_q.push_back(cyc);
        end
        if (o_dot_input_valid) dv_cyc_q.push_back(cyc);
    end

    function automatic void ref_dot(input int l, input int n, output int em, output int ee);
        longint am = 0;
        longint ae = 0;
        for (int k = 0; k < n; k++) begin
            longint m  = tab_m[(l + k) % 512];
            longint e  = tab_e[(l + k) % 512];
            longint mx = (ae > e) ? ae : e;
            longint ta = (mx - ae > 31) ? 0 : (am >>> (mx - ae));
            longint tb = (mx - e > 31) ? 0 : (m >>> (mx - e));
            longint s  = ta + tb;
            if (k == 0) begin
                am = m;
                ae = e;
            end else begin
                if (s > LMAX) s = LMAX;
                if (s < LMIN) s = LMIN;
                am = s;
                ae = mx;
            end
        end
        em = int'(am);
        ee = int'(ae);
    endfunction

    task automatic fill_tabs(input int erange);
        for (int i = 0; i < 512; i++) begin
            tab_m[i] = int'($urandom) >>> $urandom_range(0, 24);
            tab_e[i] = int'($urandom_range(0, 2 * erange)) - erange;
        end
    endtask

    task automatic issue(input int l, input int r, input int n, output int t0);
        checks++;
        if (o_cmd_ready !== 1'b1) $display("FAIL cmd_ready_at_issue: got %b expected 1", o_cmd_ready);
        rd_la_q.delete();
        rd_ra_q.delete();
        rd_cyc_q.delete();
        dv_cyc_q.delete();
        i_cmd_valid      = 1'b1;
        i_cmd_left_base  = 9'(l);
        i_cmd_right_base = 9'(r);
        i_cmd_num_nv     = 8'(n);
        t0 = cyc;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output int tv);
        tv = -1;
        for (int i = 0; i < 400; i++) begin
            if (o_result_valid === 1'b1) begin
                tv = cyc;
                break;
            end
            checks++;
            if (o_cmd_ready !== 1'b0 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_flags: cmd_ready=%b busy=%b expected 0/1", o_cmd_ready, o_busy);
            end
            @(negedge i_clk);
        end
        if (tv < 0) begin
            errors++;
            checks++;
            $display("FAIL result_timeout: no o_result_valid within 400 cycles");
        end
    endtask

    task automatic run_cmd(input int l, input int r, input int n, input int em, input int ee, input string name);
        int t0, tv, exp_tv;
        bit ok;
        issue(l, r, n, t0);
        wait_valid(tv);
        exp_tv = (n == 0) ? t0 + 1 : t0 + n + 5;
        checks++;
        if (tv != exp_tv) begin
            errors++;
            $display("FAIL %s latency: valid at cycle %0d expected %0d", name, tv - t0, exp_tv - t0);
        end
        checks++;
        if (o_result_mantissa !== 32'(em) || o_result_exponent !== 8'(ee)) begin
            errors++;
            $display("FAIL %s result: got (%0d,%0d) expected (%0d,%0d)", name,
                     o_result_mantissa, o_result_exponent, em, ee);
        end
        ok = (rd_la_q.size() == n) && (rd_ra_q.size() == n) && (dv_cyc_q.size() == n);
        if (ok) begin
            for (int k = 0; k < n; k++) begin
                if (rd_la_q[k] != (l + k) % 512 || rd_ra_q[k] != (r + k) % 512 ||
                    rd_cyc_q[k] != t0 + 1 + k || dv_cyc_q[k] != t0 + 2 + k) ok = 1'b0;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s reads: got %0d reads / %0d dot valids, expected %0d from left %0d right %0d in cycles 1..%0d",
                     name, rd_la_q.size(), dv_cyc_q.size(), n, l, r, n);
        end
        i_result_ready = 1'b1;
        @(negedge i_clk);
        i_result_ready = 1'b0;
        checks++;
        if (o_result_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: valid=%b cmd_ready=%b expected 0/1", name, o_result_valid, o_cmd_ready);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_cmd_ready, o_busy, o_rd_en, o_rd_addr_left, o_rd_addr_right, o_dot_input_valid,
             o_result_valid, o_result_mantissa, o_result_exponent} !== {1'b1, 62'b0}) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", {o_cmd_ready, o_busy, o_rd_en, o_rd_addr_left,
                     o_rd_addr_right, o_dot_input_valid, o_result_valid, o_result_mantissa, o_result_exponent},
                     {1'b1, 62'b0});
        end
        i_reset_n = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0 || o_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: cmd_ready=%b busy=%b rd_en=%b expected 1/0/0", o_cmd_ready, o_busy, o_rd_en);
        end
    endtask

    task automatic test_single;
        tab_m[0] = 100; tab_e[0] = -4;
        run_cmd(0, 0, 1, 100, -4, "single");
    endtask

    task automatic test_three;
        tab_m[0] = 64; tab_e[0] = 2;
        tab_m[1] = 64; tab_e[1] = 0;
        tab_m[2] = -8; tab_e[2] = 2;
        run_cmd(0, 0, 3, 72, 2, "three");
    endtask

    task automatic test_wrap;
        tab_m[510] = 10; tab_e[510] = 1;
        tab_m[511] = 20; tab_e[511] = 1;
        tab_m[0]   = 30; tab_e[0]   = 1;
        tab_m[1]   = -4; tab_e[1]   = 3;
        run_cmd(510, 5, 4, 11, 3, "wrap");
    endtask

    task automatic test_saturation;
        int mn;
        mn = 32'sh8000_0000;
        tab_m[0] = 2147483647; tab_e[0] = 0;
        tab_m[1] = 2147483647; tab_e[1] = 0;
        run_cmd(0, 0, 2, 2147483647, 0, "sat_pos");
        tab_m[2] = mn; tab_e[2] = 0;
        tab_m[3] = mn; tab_e[3] = 0;
        run_cmd(2, 0, 2, mn, 0, "sat_neg");
        tab_m[4] = 1000;   tab_e[4] = 40;
        tab_m[5] = 123456; tab_e[5] = 0;
        run_cmd(4, 9, 2, 1000, 40, "diff40");
        tab_m[6] = 1000; tab_e[6] = 31;
        tab_m[7] = mn;   tab_e[7] = 0;
        run_cmd(6, 0, 2, 999, 31, "diff31");
        tab_m[8] = 5;  tab_e[8] = 32;
        tab_m[9] = mn; tab_e[9] = 0;
        run_cmd(8, 0, 2, 5, 32, "diff32");
    endtask

    task automatic test_count_zero;
        run_cmd(3, 4, 0, 0, 0, "count0");
    endtask

    task automatic test_backpressure;
        int t0, tv;
        tab_m[20] = 7; tab_e[20] = 1;
        tab_m[21] = 9; tab_e[21] = 1;
        issue(20, 40, 2, t0);
        wait_valid(tv);
        checks++;
        if (tv != t0 + 7) begin
            errors++;
            $display("FAIL bp_latency: valid at cycle %0d expected 7", tv - t0);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                i_cmd_valid     = 1'b1;
                i_cmd_left_base = 9'd77;
                i_cmd_num_nv    = 8'd5;
            end
            if (i == 7) i_cmd_valid = 1'b0;
            @(negedge i_clk);
            checks++;
            if (o_result_valid !== 1'b1 || o_result_mantissa !== 32'sd16 || o_result_exponent !== 8'sd1 ||
                o_cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: valid=%b res=(%0d,%0d) cmd_ready=%b expected 1 (16,1) 0",
                         o_result_valid, o_result_mantissa, o_result_exponent, o_cmd_ready);
            end
        end
        checks++;
        if (rd_la_q.size() != 2) begin
            errors++;
            $display("FAIL bp_no_new_reads: got %0d reads expected 2", rd_la_q.size());
        end
        i_result_ready = 1'b1;
        @(negedge i_clk);
        i_result_ready = 1'b0;
        checks++;
        if (o_result_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: valid=%b cmd_ready=%b busy=%b expected 0/1/0", o_result_valid, o_cmd_ready, o_busy);
        end
    endtask

    task automatic test_back_to_back;
        int em, ee;
        fill_tabs(12);
        ref_dot(100, 6, em, ee);
        run_cmd(100, 200, 6, em, ee, "b2b_a");
        ref_dot(300, 9, em, ee);
        run_cmd(300, 50, 9, em, ee, "b2b_b");
    endtask

    task automatic test_reset_mid;
        int t0;
        fill_tabs(10);
        issue(0, 0, 8, t0);
        repeat (9) @(negedge i_clk);
        i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_cmd_ready, o_busy, o_rd_en, o_rd_addr_left, o_rd_addr_right, o_dot_input_valid,
             o_result_valid, o_result_mantissa, o_result_exponent} !== {1'b1, 62'b0}) begin
            errors++;
            $display("FAIL reset_mid_values: got %h expected %h", {o_cmd_ready, o_busy, o_rd_en, o_rd_addr_left,
                     o_rd_addr_right, o_dot_input_valid, o_result_valid, o_result_mantissa, o_result_exponent},
                     {1'b1, 62'b0});
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        tab_m[300] = 55; tab_e[300] = 7;
        run_cmd(300, 12, 1, 55, 7, "after_reset");
    endtask

    task automatic test_random;
        int l, r, n, em, ee;
        for (int it = 0; it < 25; it++) begin
            fill_tabs((it % 4 == 0) ? 100 : 20);
            l = $urandom_range(0, 511);
            r = $urandom_range(0, 511);
            n = $urandom_range(0, 20);
            ref_dot(l, n, em, ee);
            run_cmd(l, r, n, em, ee, "random");
        end
    endtask

    initial begin
        i_reset_n        = 1'b0;
        i_cmd_valid      = 1'b0;
        i_cmd_left_base  = '0;
        i_cmd_right_base = '0;
        i_cmd_num_nv     = '0;
        i_result_ready   = 1'b0;
        i_dot_mantissa   = '0;
        i_dot_exponent   = '0;
        for (int i = 0; i < 512; i++) begin
            tab_m[i] = 0;
            tab_e[i] = 0;
        end
        test_reset();
        test_single();
        test_three();
        test_wrap();
        test_saturation();
        test_count_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
